// File: rtl/ram_to_str_pkg.sv
// Shared definitions for the RAM-to-stream playback buffer.
package ram_to_str_pkg;
   localparam logic [3:0] REG_CTL = 4'h0;
   localparam logic [3:0] REG_LEN = 4'h4;
   localparam logic [3:0] REG_STS = 4'h8;

   localparam int CTL_START = 0;
   localparam int CTL_STOP  = 1;
   localparam int CTL_LOOP  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/ram_to_str_if.sv
// CPU sys bus and AXI4-Stream bundles used by the playback buffer.
interface sys_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (output addr, wdata, wen, ren, input rdata, ack, err);
   modport slave  (input addr, wdata, wen, ren, output rdata, ack, err);
endinterface

interface axis_if;
   logic [15:0] TDATA;
   logic        TVALID;
   logic        TREADY;
   logic        TLAST;

   modport master (output TDATA, TVALID, TLAST, input TREADY);
   modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/ram_to_str_skid2.sv
// Two-entry output buffer; "free" reports slots available after this cycle's pop.
module axi4_stream_skid2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   free,
   output logic         empty
);
   logic [1:0]   cnt;
   logic [W-1:0] spare;
   logic         pop;

   assign out_valid = (cnt != 2'd0);
   assign empty     = (cnt == 2'd0);
   assign pop       = out_valid & out_ready;
   assign free      = 2'd2 - cnt + {1'b0, pop};

   // Pushes only arrive when the sequencer was granted credit, so cnt never exceeds 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 2'd0;
         out_data <= '0;
         spare    <= '0;
      end else begin
         case ({pop, in_valid})
            2'b01: begin
               if (cnt == 2'd0) begin
                  out_data <= in_data;
                  cnt      <= 2'd1;
               end else begin
                  spare <= in_data;
                  cnt   <= 2'd2;
               end
            end
            2'b10: begin
               if (cnt == 2'd2) out_data <= spare;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  out_data <= in_data;
               end else begin
                  out_data <= spare;
                  spare    <= in_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/ram_to_str.sv
// Playback buffer: CPU fills a sample RAM, a sequencer streams it out one-shot or looped.
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | fetching samples from RAM into the output buffer
//  DRAIN | no new fetches; waiting for buffer and read pipe to empty
module ram_to_str
   import ram_to_str_pkg::*;
#(
   parameter int AW = 14
) (
   input  logic     clk,
   input  logic     rst,
   sys_bus_if.slave bus,
   axis_if.master   str
);
   logic [31:0]   mem [0:(1<<(AW-1))-1];
   logic [31:0]   rd_word;
   logic          reg_sel;
   logic [3:0]    reg_off;
   logic          wr_ctl, start_cmd, stop_cmd;
   logic          loop_en, done;
   logic [AW-1:0] len, ptr;
   logic [31:0]   rd_mux;
   state_t        state;
   logic          fetch, at_end;
   logic          rd_valid, rd_last, rd_hi;
   logic [1:0]    free;
   logic          skid_empty, skid_valid;
   logic [16:0]   skid_out;
   logic          unused_addr;

   assign reg_sel     = bus.addr[AW+1];
   assign reg_off     = bus.addr[3:0];
   assign wr_ctl      = bus.wen & reg_sel & (reg_off == REG_CTL);
   assign start_cmd   = wr_ctl & bus.wdata[CTL_START];
   assign stop_cmd    = wr_ctl & bus.wdata[CTL_STOP];
   assign bus.err     = 1'b0;
   assign unused_addr = ^bus.addr[31:AW+2];

   always_comb begin
      rd_mux = '0;
      if (reg_sel) begin
         case (reg_off)
            REG_CTL: rd_mux[CTL_LOOP] = loop_en;
            REG_LEN: rd_mux[AW-1:0]   = len;
            REG_STS: begin
               rd_mux[0]       = (state != IDLE);
               rd_mux[1]       = done;
               rd_mux[16 +: AW] = ptr;
            end
            default: rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ack   <= 1'b0;
         bus.rdata <= '0;
         len       <= '1;
         loop_en   <= 1'b0;
      end else begin
         bus.ack   <= bus.wen | bus.ren;
         bus.rdata <= bus.ren ? rd_mux : 32'd0;
         if (wr_ctl) loop_en <= bus.wdata[CTL_LOOP];
         if (bus.wen && reg_sel && reg_off == REG_LEN) len <= bus.wdata[AW-1:0];
      end
   end

   // Both ports use non-blocking updates, so a same-word collision reads the old data.
   always_ff @(posedge clk) begin
      if (bus.wen && !reg_sel) mem[bus.addr[AW:2]] <= bus.wdata;
      if (fetch) rd_word <= mem[ptr[AW-1:1]];
   end

   // ">=" keeps a LEN shrunk below the live pointer from running through the whole RAM.
   assign at_end = (ptr >= len);
   assign fetch  = (state == RUN) && !stop_cmd && (free > {1'b0, rd_valid});

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_hi    <= 1'b0;
      end else begin
         rd_valid <= fetch;
         rd_last  <= at_end;
         rd_hi    <= ptr[0];
         case (state)
            IDLE: begin
               if (start_cmd && !stop_cmd) begin
                  state <= RUN;
                  ptr   <= '0;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (stop_cmd) begin
                  state <= DRAIN;
               end else if (fetch) begin
                  if (at_end) begin
                     ptr <= '0;
                     if (!loop_en) state <= DRAIN;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (skid_empty && !rd_valid) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axi4_stream_skid2 #(.W(17)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_valid),
      .in_data   ({rd_last, rd_hi ? rd_word[31:16] : rd_word[15:0]}),
      .out_ready (str.TREADY),
      .out_valid (skid_valid),
      .out_data  (skid_out),
      .free      (free),
      .empty     (skid_empty)
   );

   assign str.TVALID = skid_valid;
   assign str.TDATA  = skid_out[15:0];
   assign str.TLAST  = skid_out[16];
endmodule

// File: tb/tb_ram_to_str.sv
// Bench for ram_to_str: register vector table, stream scoreboard, multi-cycle corner sequences.
module tb_ram_to_str;
   localparam int AW = 14;
   localparam logic [31:0] REG  = 32'h1 << (AW+1);
   localparam logic [31:0] A_CTL = REG | 32'h0;
   localparam logic [31:0] A_LEN = REG | 32'h4;
   localparam logic [31:0] A_STS = REG | 32'h8;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic        l;
   } beat_t;

   logic clk, rst;
   int   errors = 0, checks = 0, cyc = 0, beat_count = 0, rmode = 0;
   beat_t sb[$];

   sys_bus_if bus_i();
   axis_if    str_i();

   ram_to_str #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus_i), .str(str_i));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      str_i.TREADY = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       str_i.TREADY = 0;
            1:       str_i.TREADY = 1;
            default: str_i.TREADY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Stream monitor: scoreboard compare on handshake, stability check on stall.
   logic        prev_stall = 0;
   logic [15:0] prev_d;
   logic        prev_l;
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!str_i.TVALID || str_i.TDATA !== prev_d || str_i.TLAST !== prev_l) begin
               errors++;
               $display("FAIL stall_stable: got v=%0b d=0x%0h l=%0b required v=1 d=0x%0h l=%0b",
                        str_i.TVALID, str_i.TDATA, str_i.TLAST, prev_d, prev_l);
            end
         end
         if (str_i.TVALID && str_i.TREADY) begin
            beat_count++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got d=0x%0h l=%0b required no beat", str_i.TDATA, str_i.TLAST);
            end else begin
               e = sb.pop_front();
               if (str_i.TDATA !== e.d || str_i.TLAST !== e.l) begin
                  errors++;
                  $display("FAIL beat_%0d: got d=0x%0h l=%0b required d=0x%0h l=%0b",
                           beat_count, str_i.TDATA, str_i.TLAST, e.d, e.l);
               end
            end
         end
         prev_stall = str_i.TVALID && !str_i.TREADY;
         prev_d     = str_i.TDATA;
         prev_l     = str_i.TLAST;
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int n);
      @(posedge clk);
      #1;
      bus_i.addr = a; bus_i.wdata = d; bus_i.wen = 1;
      n = cyc;
      @(posedge clk);
      #1;
      bus_i.wen = 0;
      check("wr_ack", 32'(bus_i.ack), 1);
      check("wr_err", 32'(bus_i.err), 0);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(posedge clk);
      #1;
      bus_i.addr = a; bus_i.ren = 1;
      @(posedge clk);
      #1;
      bus_i.ren = 0;
      check("rd_ack", 32'(bus_i.ack), 1);
      check("rd_err", 32'(bus_i.err), 0);
      d = bus_i.rdata;
   endtask

   task automatic wait_idle();
      logic [31:0] s = 32'h1;
      for (int i = 0; i < 100; i++) begin
         bus_read(A_STS, s);
         if (!s[0]) break;
      end
      check("wait_idle_busy", 32'(s[0]), 0);
   endtask

   task automatic wait_beats(input int target, input int bound);
      for (int i = 0; i < bound && beat_count < target; i++) @(negedge clk);
      check("beats_reached", 32'(beat_count >= target), 1);
   endtask

   task automatic wait_sb_empty(input int bound);
      for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 0);
   endtask

   task automatic push_seq(input int first, input int count, input int last_every);
      beat_t b;
      for (int i = 0; i < count; i++) begin
         b.d = 16'(first + (i % last_every));
         b.l = ((i % last_every) == last_every - 1);
         sb.push_back(b);
      end
   endtask

   initial begin
      vec_t        vecs[12];
      logic [31:0] rd;
      int          n, hs, snap;
      beat_t       b;

      vecs[0]  = '{0, A_CTL, 0, 32'h0};
      vecs[1]  = '{0, A_LEN, 0, 32'h3FFF};
      vecs[2]  = '{0, A_STS, 0, 32'h0};
      vecs[3]  = '{1, A_LEN, 5, 0};
      vecs[4]  = '{0, A_LEN, 0, 32'h5};
      vecs[5]  = '{1, A_CTL, 32'h4, 0};
      vecs[6]  = '{0, A_CTL, 0, 32'h4};
      vecs[7]  = '{1, A_CTL, 32'h0, 0};
      vecs[8]  = '{0, REG | 32'hC, 0, 32'h0};
      vecs[9]  = '{0, 32'h0, 0, 32'h0};
      vecs[10] = '{1, A_LEN, 32'hFFFF_FFFF, 0};
      vecs[11] = '{0, A_LEN, 0, 32'h3FFF};

      rst = 1;
      bus_i.addr = 0; bus_i.wdata = 0; bus_i.wen = 0; bus_i.ren = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 32'(str_i.TVALID), 0);
      check("rst_tdata", 32'(str_i.TDATA), 0);
      check("rst_tlast", 32'(str_i.TLAST), 0);
      check("rst_ack", 32'(bus_i.ack), 0);
      check("rst_rdata", bus_i.rdata, 0);
      rst = 0;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, n);
         else begin
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
         end
      end

      // One-shot, full throughput, latency and TLAST placement.
      bus_write(32'h0, 32'h0002_0001, n);
      bus_write(32'h4, 32'h0004_0003, n);
      bus_write(32'h8, 32'h0006_0005, n);
      bus_write(32'hC, 32'h0008_0007, n);
      bus_write(A_LEN, 7, n);
      rmode = 1;
      push_seq(1, 8, 8);
      bus_write(A_CTL, 32'h1, n);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (str_i.TVALID) break;
      end
      check("first_tvalid_latency", 32'(cyc - n), 3);
      hs = 0;
      for (int i = 0; i < 8; i++) begin
         if (str_i.TVALID && str_i.TREADY) hs++;
         @(negedge clk);
      end
      check("consecutive_beats", 32'(hs), 8);
      check("no_ninth_beat", 32'(str_i.TVALID), 0);
      wait_idle();
      bus_read(A_STS, rd);
      check("sts_after_oneshot", rd, 32'h2);
      check("sb_empty_t1", 32'(sb.size()), 0);

      // Random backpressure, same sequence.
      rmode = 2;
      push_seq(1, 8, 8);
      bus_write(A_CTL, 32'h1, n);
      wait_sb_empty(300);
      wait_idle();
      bus_read(A_STS, rd);
      check("sts_after_random", rd, 32'h2);

      // Start while busy is ignored.
      rmode = 1;
      snap = beat_count;
      push_seq(1, 8, 8);
      bus_write(A_CTL, 32'h1, n);
      bus_write(A_CTL, 32'h1, n);
      wait_sb_empty(200);
      wait_idle();
      check("restart_ignored_beats", 32'(beat_count - snap), 8);

      // Start and stop together from IDLE.
      bus_write(A_CTL, 32'h3, n);
      hs = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (str_i.TVALID) hs++;
      end
      check("start_stop_no_tvalid", 32'(hs), 0);
      bus_read(A_STS, rd);
      check("start_stop_busy", 32'(rd[0]), 0);

      // Loop mode, LEN=3, three passes then stop.
      bus_write(A_LEN, 3, n);
      push_seq(1, 24, 4);
      snap = beat_count;
      bus_write(A_CTL, 32'h5, n);
      wait_beats(snap + 12, 200);
      bus_write(A_CTL, 32'h6, n);
      snap = beat_count;
      wait_idle();
      check("beats_after_stop_le2", 32'((beat_count - snap) <= 2), 1);
      bus_read(A_STS, rd);
      check("sts_after_loop_stop", rd & 32'h3, 32'h2);
      sb.delete();

      // Full-length loop over index-valued RAM with wrap.
      for (int k = 0; k < (1 << (AW-1)); k++) begin
         @(posedge clk);
         #1;
         bus_i.addr = 32'(k * 4);
         bus_i.wdata = {16'(2*k + 1), 16'(2*k)};
         bus_i.wen = 1;
      end
      @(posedge clk);
      #1;
      bus_i.wen = 0;
      bus_write(A_LEN, 32'h3FFF, n);
      for (int i = 0; i < (1 << AW); i++) begin
         b.d = 16'(i); b.l = (i == (1 << AW) - 1);
         sb.push_back(b);
      end
      for (int i = 0; i < 40; i++) begin
         b.d = 16'(i); b.l = 0;
         sb.push_back(b);
      end
      snap = beat_count;
      bus_write(A_CTL, 32'h5, n);
      wait_beats(snap + (1 << AW) + 10, 20000);
      bus_write(A_CTL, 32'h6, n);
      wait_idle();
      sb.delete();

      // Reset mid-stream while stalled.
      rmode = 0;
      bus_write(A_CTL, 32'h5, n);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (str_i.TVALID) break;
      end
      check("tvalid_before_rst", 32'(str_i.TVALID), 1);
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      check("rst_mid_tvalid", 32'(str_i.TVALID), 0);
      check("rst_mid_tdata", 32'(str_i.TDATA), 0);
      bus_read(A_STS, rd);
      check("rst_mid_sts", rd, 32'h0);
      bus_read(A_LEN, rd);
      check("rst_mid_len", rd, 32'h3FFF);
      bus_read(A_CTL, rd);
      check("rst_mid_ctl", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
